// File: rtl/weight_loader_if.sv
// weight_loader_if: groups the tile loader's control, input stream and
// weight-memory write bus.
//   start/base_addr    : tile request and first destination address
//   in_valid/in_ready  : input word handshake, in_data carries the word
//   wr_en/wr_addr/wr_data : weight-memory write port
//   busy/done          : transfer status, done is a one-cycle pulse
// slave = the loader, master = whoever feeds it.
interface weight_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;

  modport slave (
    input  start, base_addr, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, busy, done
  );

  modport master (
    output start, base_addr, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/weight_loader.sv
// weight_loader: buffers an N x N weight tile arriving row-major on a
// valid/ready stream, then writes it to weight memory column-major
// (transposed), one word per cycle starting at the latched base address.
// Ports:
//   clk   : clock, rising edge active
//   reset : asynchronous active-high reset
//   bus   : weight_loader_if.slave (start, base_addr, in_valid/in_ready,
//           in_data, wr_en, wr_addr, wr_data, busy, done)
// Every output is a function of registered state only; nothing combinational
// runs from an input to an output.
module weight_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13,
  parameter int N      = 2
) (
  input  logic            clk,
  input  logic            reset,
  weight_loader_if.slave  bus
);

  localparam int NN = N * N;
  localparam int CW = (NN > 1) ? $clog2(NN) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                       r_state;
  logic [CW-1:0]                r_k;      // words accepted so far
  logic [CW-1:0]                r_j;      // writes issued so far
  logic [ADDR_W-1:0]            r_base;
  logic                         r_in_ready;
  logic                         r_wr_en;
  logic                         r_busy;
  logic                         r_done;
  logic [NN-1:0][DATA_W-1:0]    r_buf;    // tile in row-major order

  logic [CW-1:0]                w_rd_idx;
  logic                         w_accept;

  // in_ready is a registered flag that is high exactly in LOAD, so the
  // accept term only needs the state and in_valid.
  assign w_accept = (r_state == S_LOAD) && bus.in_valid;

  // Write j walks the tile column-major: row j mod N, column j / N.
  always_comb begin
    w_rd_idx = CW'((int'(r_j) % N) * N + int'(r_j) / N);
  end

  // Status flags are registered next to the state so they always agree
  // with it; reset clears all of them at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_j        <= '0;
      r_base     <= '0;
      r_in_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_base     <= bus.base_addr;
            r_k        <= '0;
            r_j        <= '0;
            r_state    <= S_LOAD;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_k <= r_k + CW'(1);
            if (r_k == CW'(NN - 1)) begin
              r_state    <= S_WRITE;
              r_in_ready <= 1'b0;
              r_wr_en    <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          r_j <= r_j + CW'(1);
          if (r_j == CW'(NN - 1)) begin
            r_state <= S_DONE;
            r_wr_en <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          // start seen here is dropped; IDLE picks it up next cycle.
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_wr_en    <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  // Tile storage carries no reset: every entry is rewritten in LOAD before
  // WRITE can read it.
  always_ff @(posedge clk) begin
    if (w_accept)
      r_buf[r_k] <= bus.in_data;
  end

  assign bus.in_ready = r_in_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  // ADDR_W-bit addition wraps past the top of memory back to address 0.
  assign bus.wr_addr  = r_wr_en ? (r_base + ADDR_W'(r_j)) : '0;
  assign bus.wr_data  = r_wr_en ? r_buf[w_rd_idx] : '0;

endmodule

// File: tb/tb_weight_loader.sv
module tb_weight_loader;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 13;
  localparam int N      = 2;
  localparam int NN     = N * N;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk;
  logic reset;

  weight_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  weight_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int  n_chk;
  int  n_err;
  int  cyc;
  int  done_cnt;
  int  done_cyc;
  int  ld_cyc;
  int  wr_seen;
  bit  prev_rdy;
  wr_t exp_q [$];
  logic [DATA_W-1:0] wd [2][NN];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: tile element (r,c) holds input word r*N+c; memory gets the
  // transpose, i.e. column by column, at consecutive addresses mod 2^ADDR_W.
  task automatic model_push(input logic [ADDR_W-1:0] base, input int t);
    logic [DATA_W-1:0] tile [N][N];
    wr_t e;
    for (int k = 0; k < NN; k++) tile[k / N][k % N] = wd[t][k];
    for (int c = 0; c < N; c++)
      for (int r = 0; r < N; r++) begin
        e.addr = ADDR_W'((int'(base) + c * N + r) % (1 << ADDR_W));
        e.data = tile[r][c];
        exp_q.push_back(e);
      end
  endtask

  // Present one word and hold it until an edge where in_ready was high.
  task automatic feed_word(input logic [DATA_W-1:0] d);
    bit acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int t = 0; t < 200 && !acc; t++) begin
      acc = bus.in_ready;
      tick();
    end
    if (!acc) chk("accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int t = 0; t < budget && !ok; t++) begin
      tick();
      if (done_cnt > d0) ok = 1'b1;
    end
  endtask

  task automatic run_tile(input logic [ADDR_W-1:0] base, input int stall_at,
                          input int stall_len, input bit noise);
    int s, d0;
    bit ok;
    model_push(base, 0);
    d0 = done_cnt;
    bus.start     = 1'b1;
    bus.base_addr = base;
    s = cyc;
    tick();
    bus.start     = noise;
    bus.base_addr = base ^ 13'h0A5A;
    for (int w = 0; w < NN; w++) begin
      if (w == stall_at)
        repeat (stall_len) begin
          bus.in_valid = 1'b0;
          chk("stall_ready", bus.in_ready, 1);
          tick();
        end
      feed_word(wd[0][w]);
    end
    chk("ready_after_last", bus.in_ready, 0);
    if (noise) begin
      tick();
      tick();
    end
    bus.start = 1'b0;
    wait_done(60, ok);
    chk("done_seen", ok, 1);
    chk("latency", done_cyc - s + 1, 2 * NN + 2 + stall_len);
    tick();
    tick();
    chk("done_once", done_cnt - d0, 1);
    chk("writes_drained", exp_q.size(), 0);
    chk("busy_idle", bus.busy, 0);
  endtask

  task automatic fill_rand(input int t);
    for (int k = 0; k < NN; k++) wd[t][k] = DATA_W'($urandom);
  endtask

  // Bus monitor: every write must be the next one the model predicts.
  initial begin
    wr_t e;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.wr_en) begin
          wr_seen++;
          if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("wr_addr", bus.wr_addr, e.addr);
            chk("wr_data", bus.wr_data, e.data);
          end
        end else begin
          chk("bus_idle", {bus.wr_addr, bus.wr_data}, 0);
        end
        if (bus.done) begin
          done_cnt++;
          done_cyc = cyc;
          chk("done_no_write", bus.wr_en, 0);
        end
        if (bus.in_ready || bus.wr_en || bus.done) chk("busy_active", bus.busy, 1);
        if (bus.in_ready && !prev_rdy) ld_cyc = cyc;
        prev_rdy = bus.in_ready;
      end else begin
        prev_rdy = 1'b0;
      end
    end
  end

  initial begin
    int d0, w0, b1, b2;
    bit ok;
    n_chk = 0; n_err = 0; done_cnt = 0; wr_seen = 0;
    done_cyc = 0; ld_cyc = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.base_addr = '0; bus.in_valid = 1'b0; bus.in_data = '0;

    // Reset state
    #2 reset = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_wr_en",    bus.wr_en,    0);
    chk("rst_wr_addr",  bus.wr_addr,  0);
    chk("rst_wr_data",  bus.wr_data,  0);
    chk("rst_busy",     bus.busy,     0);
    chk("rst_done",     bus.done,     0);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("idle_ready", bus.in_ready, 0);

    // Directed tile 3,4,5,6 at 0x000F, no stall, then with a 3-cycle stall
    for (int k = 0; k < NN; k++) wd[0][k] = DATA_W'(k + 3);
    run_tile(13'h000F, NN, 0, 1'b0);
    run_tile(13'h000F, 2, 3, 1'b0);

    // Wrap across the top of the address space
    for (int k = 0; k < NN; k++) wd[0][k] = DATA_W'(k + 1);
    run_tile(13'h1FFE, NN, 0, 1'b0);

    // start with a different base during LOAD and WRITE
    fill_rand(0);
    run_tile(13'h0123, 1, 2, 1'b1);

    // Reset after the second write of a transfer
    fill_rand(0);
    model_push(13'h0400, 0);
    d0 = done_cnt;
    bus.start = 1'b1; bus.base_addr = 13'h0400;
    tick();
    bus.start = 1'b0;
    for (int w = 0; w < NN; w++) feed_word(wd[0][w]);
    w0 = wr_seen;
    for (int t = 0; t < 50 && wr_seen < w0 + 2; t++) begin
      @(negedge clk);
      #2;
    end
    chk("rst_two_writes", wr_seen - w0, 2);
    reset = 1'b1;
    #1;
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_wr_en",    bus.wr_en,    0);
    chk("abort_wr_addr",  bus.wr_addr,  0);
    chk("abort_wr_data",  bus.wr_data,  0);
    chk("abort_busy",     bus.busy,     0);
    chk("abort_done",     bus.done,     0);
    exp_q.delete();
    tick(); tick();
    reset = 1'b0;
    repeat (8) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    fill_rand(0);
    run_tile(13'h0777, NN, 0, 1'b0);

    // Back-to-back tiles with start held high
    fill_rand(0); fill_rand(1);
    b1 = $urandom_range(0, (1 << ADDR_W) - 1);
    b2 = $urandom_range(0, (1 << ADDR_W) - 1);
    model_push(ADDR_W'(b1), 0);
    model_push(ADDR_W'(b2), 1);
    d0 = done_cnt;
    bus.start = 1'b1; bus.base_addr = ADDR_W'(b1);
    tick();
    bus.base_addr = ADDR_W'(b2);
    for (int w = 0; w < NN; w++) feed_word(wd[0][w]);
    feed_word(wd[1][0]);
    bus.start = 1'b0;
    chk("b2b_first_done", done_cnt - d0, 1);
    chk("b2b_restart_gap", ld_cyc - done_cyc, 2);
    for (int w = 1; w < NN; w++) feed_word(wd[1][w]);
    wait_done(60, ok);
    chk("b2b_second_done", ok, 1);
    tick(); tick();
    chk("b2b_done_total", done_cnt - d0, 2);
    chk("b2b_drained", exp_q.size(), 0);

    // Randomized tiles: random base (often near the top), stalls, start noise
    for (int i = 0; i < 10; i++) begin
      fill_rand(0);
      if ($urandom_range(0, 1) == 1) b1 = (1 << ADDR_W) - 1 - int'($urandom_range(0, NN));
      else b1 = $urandom_range(0, (1 << ADDR_W) - 1);
      run_tile(ADDR_W'(b1), $urandom_range(0, NN - 1), $urandom_range(0, 4),
               1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
